// File: rtl/mul_slave_pkg.sv
// Shared constants for the mul_slave bus responder: register indices,
// OPCODE/STATUS bit positions and FSM state encoding.
package mul_slave_pkg;

    localparam logic [2:0] REG_OPA      = 3'd0;
    localparam logic [2:0] REG_OPB      = 3'd1;
    localparam logic [2:0] REG_OPCODE   = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_RESULT_H = 3'd4;
    localparam logic [2:0] REG_RESULT_L = 3'd5;
    localparam logic [2:0] REG_INTR_EN  = 3'd6;

    localparam int OP_START = 0;
    localparam int OP_CLEAR = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/booth_mul_core.sv
// Iterative signed radix-2 Booth multiplier: one add/sub-and-shift step per
// cycle, DATA_W steps per product.
module booth_mul_core #(
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand;
    // One guard bit above the accumulator keeps most-negative x most-negative exact.
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] mplier;
    logic              q_1;
    logic [CNT_W-1:0]  step;
    logic              running;
    logic [DATA_W:0]   sum;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        sum = acc;
        case ({mplier[0], q_1})
            2'b01:   sum = acc + {mcand[DATA_W-1], mcand};
            2'b10:   sum = acc - {mcand[DATA_W-1], mcand};
            default: sum = acc;
        endcase
    end

    // High during the final step; the product is complete after that edge.
    assign done    = running && (step == CNT_W'(DATA_W - 1));
    assign busy    = running;
    assign product = {acc[DATA_W-1:0], mplier};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            q_1     <= 1'b0;
            step    <= '0;
            running <= 1'b0;
        end else if (clear) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            q_1     <= 1'b0;
            step    <= '0;
            running <= 1'b0;
        end else if (start && !running) begin
            mcand   <= a;
            acc     <= '0;
            mplier  <= b;
            q_1     <= 1'b0;
            step    <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc     <= {sum[DATA_W], sum[DATA_W:1]};
            mplier  <= {sum[0], mplier[DATA_W-1:1]};
            q_1     <= mplier[0];
            step    <= step + CNT_W'(1);
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_slave.sv
// Bus slave wrapping booth_mul_core behind an 8-entry register map.
// Define MUL_SLAVE_INTR_EN to implement INTR_EN and the s_interrupt output.
module mul_slave
    import mul_slave_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int REG_IDX_LSB = 3,
    parameter int REG_IDX_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [15:0]       s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              s_interrupt
);

    logic [REG_IDX_W-1:0] idx;
    logic                 wr_en;
    logic                 rd_en;
    logic                 op_start;
    logic                 op_clear;
    logic [1:0]           state;
    logic [DATA_W-1:0]    opa;
    logic [DATA_W-1:0]    opb;
    logic                 core_busy;
    logic                 core_done;
    logic [2*DATA_W-1:0]  product;
    logic                 intr_en;
    logic                 unused_bits;

    assign idx   = s_addr[REG_IDX_LSB +: REG_IDX_W];
    assign wr_en = s_sel && s_wr;
    assign rd_en = s_sel && !s_wr;

    // Clear outranks start in the same write; start is ignored mid-operation.
    assign op_clear = wr_en && (idx == REG_OPCODE) && s_din[OP_CLEAR];
    assign op_start = wr_en && (idx == REG_OPCODE) && s_din[OP_START]
                      && !s_din[OP_CLEAR] && (state != S_EXEC);

    assign unused_bits = ^{s_addr, s_din};

    booth_mul_core #(.DATA_W(DATA_W)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (op_start),
        .clear   (op_clear),
        .a       (opa),
        .b       (opb),
        .busy    (core_busy),
        .done    (core_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else if (op_clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (op_start)  state <= S_EXEC;
                S_EXEC:  if (core_done) state <= S_DONE;
                S_DONE:  if (op_start)  state <= S_EXEC;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa <= '0;
            opb <= '0;
        end else if (wr_en) begin
            if (idx == REG_OPA) opa <= s_din;
            if (idx == REG_OPB) opb <= s_din;
        end
    end

`ifdef MUL_SLAVE_INTR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         intr_en <= 1'b0;
        else if (wr_en && idx == REG_INTR_EN) intr_en <= s_din[0];
    end
`else
    assign intr_en = 1'b0;
`endif

    // Leaving DONE (clear or a new start) drops the level interrupt.
    assign s_interrupt = (state == S_DONE) && intr_en;

    always_comb begin
        s_dout = '0;
        if (rd_en) begin
            case (idx)
                REG_OPA:      s_dout = opa;
                REG_OPB:      s_dout = opb;
                REG_STATUS: begin
                    s_dout[STAT_BUSY] = core_busy;
                    s_dout[STAT_DONE] = (state == S_DONE);
                end
                REG_RESULT_H: if (state == S_DONE) s_dout = product[2*DATA_W-1:DATA_W];
                REG_RESULT_L: if (state == S_DONE) s_dout = product[DATA_W-1:0];
                REG_INTR_EN:  s_dout[0] = intr_en;
                default:      s_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_slave.sv
// Self-checking bench for mul_slave: vector table, randomized products against
// a plain-arithmetic model, and hand-written corner-case sequences.
module tb_mul_slave;

    logic        clk;
    logic        reset_n;
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout;
    logic        s_interrupt;

    int n_checks = 0;
    int n_errors = 0;

    mul_slave dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_sel       (s_sel),
        .s_wr        (s_wr),
        .s_addr      (s_addr),
        .s_din       (s_din),
        .s_dout      (s_dout),
        .s_interrupt (s_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_h;
        logic [63:0] exp_l;
    } vec_t;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] addr_of(input int idx);
        return 16'h7000 + 16'(idx * 8);
    endfunction

    task automatic bus_write(input int idx, input logic [63:0] data);
        s_sel  = 1'b1;
        s_wr   = 1'b1;
        s_addr = addr_of(idx);
        s_din  = data;
        @(posedge clk);
        #1;
        s_sel = 1'b0;
        s_wr  = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input int idx, output logic [63:0] data);
        s_sel  = 1'b1;
        s_wr   = 1'b0;
        s_addr = addr_of(idx);
        #1;
        data  = s_dout;
        s_sel = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        logic [63:0] st;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus_read(3, st);
            if (st[1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Reference product from plain signed arithmetic.
    function automatic logic [127:0] model_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ea;
        logic signed [127:0] eb;
        ea = $signed(a);
        eb = $signed(b);
        return ea * eb;
    endfunction

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input bit disturb, output logic [63:0] h, output logic [63:0] l);
        bus_write(0, a);
        bus_write(1, b);
        bus_write(2, 64'h1);
        if (disturb) begin
            wait_cycles(3);
            bus_write(0, {$urandom, $urandom});
            bus_write(1, {$urandom, $urandom});
        end
        wait_done(name);
        bus_read(4, h);
        bus_read(5, l);
    endtask

    vec_t        vecs[8];
    logic [63:0] rd;
    logic [63:0] h;
    logic [63:0] l;
    logic [127:0] exp_p;

    initial begin
        vecs[0] = '{"3x5",        64'd3, 64'd5, 64'h0, 64'hF};
        vecs[1] = '{"m1x2",       64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{"minxmin",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h4000_0000_0000_0000, 64'h0};
        vecs[3] = '{"7x9",        64'd7, 64'd9, 64'h0, 64'd63};
        vecs[4] = '{"m3xm4",      64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'd12};
        vecs[5] = '{"maxxmax",    64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                    64'h3FFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[6] = '{"maxxmin",    64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                    64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000};
        vecs[7] = '{"0xm5",       64'h0, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 64'h0};

        reset_n = 1'b0;
        s_sel   = 1'b0;
        s_wr    = 1'b0;
        s_addr  = '0;
        s_din   = '0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(1);

        // Reset state of every register.
        for (int i = 0; i < 8; i++) begin
            bus_read(i, rd);
            check($sformatf("reset_reg%0d", i), rd, 64'h0);
        end
        check("reset_intr", 64'(s_interrupt), 64'h0);

        // Exact latency: done appears after edge T+64, not T+63.
        bus_write(0, 64'd3);
        bus_write(1, 64'd5);
        bus_write(2, 64'h1);
        bus_read(3, rd);
        check("lat_busy_after_start", rd, 64'h1);
        wait_cycles(63);
        bus_read(3, rd);
        check("lat_status_t63", rd, 64'h1);
        bus_read(5, rd);
        check("lat_result_hidden", rd, 64'h0);
        wait_cycles(1);
        bus_read(3, rd);
        check("lat_status_t64", rd, 64'h2);
        bus_read(5, rd);
        check("lat_result_l", rd, 64'hF);

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, 1'b0, h, l);
            check({vecs[i].name, "_h"}, h, vecs[i].exp_h);
            check({vecs[i].name, "_l"}, l, vecs[i].exp_l);
        end

        // Randomized operands, some with operand rewrites mid-operation.
        for (int i = 0; i < 16; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 5 == 1) a = 64'h8000_0000_0000_0000;
            if (i % 7 == 2) b = 64'(-$signed(64'($urandom_range(100, 1))));
            exp_p = model_mul(a, b);
            run_op($sformatf("rand%0d", i), a, b, (i % 2) == 1, h, l);
            check($sformatf("rand%0d_h", i), h, exp_p[127:64]);
            check($sformatf("rand%0d_l", i), l, exp_p[63:0]);
        end

        // Start and OPA write during EXEC are ignored by the running op.
        bus_write(0, 64'd7);
        bus_write(1, 64'd9);
        bus_write(2, 64'h1);
        wait_cycles(9);
        bus_write(0, 64'd2);
        bus_write(2, 64'h1);
        wait_cycles(52);
        bus_read(3, rd);
        check("ign_status_t63", rd, 64'h1);
        wait_cycles(1);
        bus_read(3, rd);
        check("ign_status_t64", rd, 64'h2);
        bus_read(5, rd);
        check("ign_result_l", rd, 64'd63);
        bus_read(4, rd);
        check("ign_result_h", rd, 64'h0);
        bus_read(0, rd);
        check("ign_opa_readback", rd, 64'd2);

        // Start from DONE begins a new op with the current operands (2x9).
        bus_write(2, 64'h1);
        bus_read(5, rd);
        check("restart_result_hidden", rd, 64'h0);
        wait_done("restart");
        bus_read(5, rd);
        check("restart_result_l", rd, 64'd18);

        // Clear aborts EXEC; start+clear together leaves the block idle.
        bus_write(2, 64'h1);
        wait_cycles(19);
        bus_write(2, 64'h2);
        bus_read(3, rd);
        check("clr_status", rd, 64'h0);
        bus_read(4, rd);
        check("clr_result_h", rd, 64'h0);
        bus_read(5, rd);
        check("clr_result_l", rd, 64'h0);
        bus_write(2, 64'h3);
        bus_read(3, rd);
        check("clr_both_status", rd, 64'h0);
        wait_cycles(70);
        bus_read(3, rd);
        check("clr_both_status_later", rd, 64'h0);
        check("clr_intr", 64'(s_interrupt), 64'h0);

        // Unselected accesses: no read data, no register updates.
        for (int i = 0; i < 8; i++) begin
            s_sel  = 1'b0;
            s_wr   = 1'($urandom_range(1, 0));
            s_addr = 16'($urandom);
            #1;
            check($sformatf("nosel_dout%0d", i), s_dout, 64'h0);
        end
        s_sel  = 1'b0;
        s_wr   = 1'b1;
        s_addr = addr_of(0);
        s_din  = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk);
        #1;
        s_addr = addr_of(2);
        s_din  = 64'h1;
        @(posedge clk);
        #1;
        s_wr = 1'b0;
        @(negedge clk);
        bus_read(0, rd);
        check("nosel_opa_kept", rd, 64'd2);
        bus_read(3, rd);
        check("nosel_no_start", rd, 64'h0);

        // Interrupt behaviour in both builds.
        bus_write(6, 64'h1);
        bus_read(6, rd);
`ifdef MUL_SLAVE_INTR_EN
        check("intr_en_readback", rd, 64'h1);
`else
        check("intr_en_readback", rd, 64'h0);
`endif
        run_op("4x4", 64'd4, 64'd4, 1'b0, h, l);
        check("4x4_l", l, 64'd16);
`ifdef MUL_SLAVE_INTR_EN
        check("intr_at_done", 64'(s_interrupt), 64'h1);
`else
        check("intr_at_done", 64'(s_interrupt), 64'h0);
`endif
        bus_write(2, 64'h2);
        check("intr_after_clear", 64'(s_interrupt), 64'h0);

        // Async reset mid-EXEC: immediate abort, nothing completes afterwards.
        bus_write(2, 64'h1);
        wait_cycles(30);
        bus_read(3, rd);
        check("rst_busy_before", rd, 64'h1);
        reset_n = 1'b0;
        #1;
        check("rst_intr", 64'(s_interrupt), 64'h0);
        check("rst_dout_idle", s_dout, 64'h0);
        bus_read(3, rd);
        check("rst_status", rd, 64'h0);
        bus_read(0, rd);
        check("rst_opa", rd, 64'h0);
        bus_read(6, rd);
        check("rst_intr_en", rd, 64'h0);
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(1);
        bus_read(3, rd);
        check("rst_status_after", rd, 64'h0);
        wait_cycles(70);
        bus_read(3, rd);
        check("rst_status_later", rd, 64'h0);
        bus_read(5, rd);
        check("rst_result_l", rd, 64'h0);
        check("rst_intr_later", 64'(s_interrupt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
